// File: rtl/ysyx_23060124_ifu_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package ysyx_23060124_ifu_pkg;
  localparam int          ysyx_23060124_ISA_WIDTH = 32;
  localparam logic [31:0] ysyx_23060124_RESET_PC  = 32'h8000_0000;

  typedef enum logic [2:0] {
    IFU_IDLE = 3'd0,
    IFU_REQ  = 3'd1,
    IFU_WAIT = 3'd2,
    IFU_HOLD = 3'd3,
    IFU_ERR  = 3'd4
  } ifu_state_e;
endpackage

// File: rtl/ysyx_23060124_ifu_pc.sv
// Architectural PC: holds, steps by one word, or loads a word-aligned redirect target.
module ysyx_23060124_ifu_pc
  import ysyx_23060124_ifu_pkg::*;
#(
  parameter int                    ISA_WIDTH = ysyx_23060124_ISA_WIDTH,
  parameter logic [ISA_WIDTH-1:0]  RESET_PC  = ysyx_23060124_RESET_PC
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_advance,
  input  logic                 i_redirect,
  input  logic [ISA_WIDTH-1:0] i_redirect_pc,
  output logic [ISA_WIDTH-1:0] o_pc
);
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_pc <= RESET_PC;
    else if (i_redirect)
      o_pc <= {i_redirect_pc[ISA_WIDTH-1:2], 2'b00};
    else if (i_advance)
      o_pc <= o_pc + ISA_WIDTH'(4);
  end
endmodule

// File: rtl/ysyx_23060124_ifu.sv
// Instruction fetch unit: one outstanding imem fetch, valid/ready hand-off to decode,
// redirects drop stale fetches via a kill flag.
module ysyx_23060124_ifu
  import ysyx_23060124_ifu_pkg::*;
#(
  parameter int                    ISA_WIDTH = ysyx_23060124_ISA_WIDTH,
  parameter logic [ISA_WIDTH-1:0]  RESET_PC  = ysyx_23060124_RESET_PC
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_imem_req_valid,
  input  logic                 i_imem_req_ready,
  output logic [ISA_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_rsp_valid,
  input  logic [ISA_WIDTH-1:0] i_imem_rsp_data,
  input  logic                 i_imem_rsp_err,
  output logic                 o_ins_valid,
  input  logic                 i_ins_ready,
  output logic [ISA_WIDTH-1:0] o_ins,
  output logic [ISA_WIDTH-1:0] o_pc,
  input  logic                 i_redirect_valid,
  input  logic [ISA_WIDTH-1:0] i_redirect_pc,
  output logic                 o_fetch_err
);
  ifu_state_e           state;
  logic                 kill;
  logic                 redir;
  logic                 advance;
  logic [ISA_WIDTH-1:0] pc;

  // A faulted unit is frozen until reset, so redirects are masked there.
  assign redir   = i_redirect_valid && (state != IFU_ERR);
  assign advance = (state == IFU_HOLD) && i_ins_ready && !redir;

  ysyx_23060124_ifu_pc #(
    .ISA_WIDTH (ISA_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_advance     (advance),
    .i_redirect    (redir),
    .i_redirect_pc (i_redirect_pc),
    .o_pc          (pc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IFU_IDLE;
      kill  <= 1'b0;
      o_ins <= '0;
      o_pc  <= RESET_PC;
    end else begin
      case (state)
        IFU_IDLE: state <= IFU_REQ;
        IFU_REQ: if (i_imem_req_ready) begin
          // Request went out with the old pc; its response must be discarded.
          state <= IFU_WAIT;
          kill  <= redir;
        end
        IFU_WAIT: begin
          if (i_imem_rsp_valid) begin
            if (kill || redir) begin
              kill  <= 1'b0;
              state <= IFU_REQ;
            end else if (i_imem_rsp_err) begin
              state <= IFU_ERR;
            end else begin
              o_ins <= i_imem_rsp_data;
              o_pc  <= pc;
              state <= IFU_HOLD;
            end
          end else if (redir) begin
            kill <= 1'b1;
          end
        end
        IFU_HOLD: if (redir || i_ins_ready) state <= IFU_REQ;
        IFU_ERR:  state <= IFU_ERR;
        default:  state <= IFU_IDLE;
      endcase
    end
  end

  assign o_imem_req_valid = (state == IFU_REQ);
  assign o_imem_addr      = pc;
  assign o_ins_valid      = (state == IFU_HOLD);
  assign o_fetch_err      = (state == IFU_ERR);
endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// Directed bench for the fetch unit with a latency-configurable imem model and
// scoreboards for request addresses and delivered {pc, ins}.
module tb_ysyx_23060124_ifu;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready = 1'b1;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data = '0;
  logic        i_imem_rsp_err = 1'b0;
  logic        o_ins_valid;
  logic        i_ins_ready = 1'b0;
  logic [31:0] o_ins;
  logic [31:0] o_pc;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_fetch_err;

  ysyx_23060124_ifu dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
    .o_imem_addr(o_imem_addr), .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rsp_data(i_imem_rsp_data), .i_imem_rsp_err(i_imem_rsp_err),
    .o_ins_valid(o_ins_valid), .i_ins_ready(i_ins_ready),
    .o_ins(o_ins), .o_pc(o_pc),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_fetch_err(o_fetch_err)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // imem model
  int          lat = 0;
  bit          pat = 1'b0;
  bit          err_arm = 1'b0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          req_cnt = 0;
  bit          mon_en = 1'b0;

  function automatic logic [31:0] mdata(input logic [31:0] a, input bit p);
    return p ? (a ^ 32'h1357_9BDF) : 32'h0000_0013;
  endfunction

  logic [31:0] exp_req[$];
  logic [63:0] exp_ins[$];

  always @(negedge i_clk) begin
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_err   = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = mdata(pend_addr, pat);
        i_imem_rsp_err   = err_arm;
        err_arm          = 1'b0;
        pend             = 1'b0;
      end else pend_cnt--;
    end
    if (o_imem_req_valid && i_imem_req_ready && !i_rst) begin
      pend = 1'b1; pend_cnt = lat; pend_addr = o_imem_addr;
    end
  end

  // scoreboard monitors
  always @(negedge i_clk) begin
    if (mon_en && !i_rst) begin
      if (o_imem_req_valid && i_imem_req_ready) begin
        req_cnt++;
        if (exp_req.size() > 0) chk("req_addr", o_imem_addr, exp_req.pop_front());
      end
      if (o_ins_valid && i_ins_ready && exp_ins.size() > 0) begin
        logic [63:0] e;
        e = exp_ins.pop_front();
        chk("deliv_pc", o_pc, e[63:32]);
        chk("deliv_ins", o_ins, e[31:0]);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    i_rst = 1'b1; i_redirect_valid = 1'b0;
    exp_req.delete(); exp_ins.delete();
    cyc(2);
    i_rst = 1'b0;
    mon_en = 1'b1;
    cyc(1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_req.size() > 0 || exp_ins.size() > 0) && n < 30) begin cyc(1); n++; end
    chk({tag, "_drain_req"}, exp_req.size(), 0);
    chk({tag, "_drain_ins"}, exp_ins.size(), 0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_ins_valid && n < 20) begin cyc(1); n++; end
    chk({tag, "_wait_valid"}, o_ins_valid, 1);
  endtask

  initial begin
    int cnt, first, last, spacing_bad, rc;
    logic [31:0] ins0, pc0;

    // reset state
    cyc(1);
    chk("rst_req_valid", o_imem_req_valid, 0);
    chk("rst_ins_valid", o_ins_valid, 0);
    chk("rst_fetch_err", o_fetch_err, 0);
    chk("rst_o_ins", o_ins, 32'h0);
    chk("rst_o_pc", o_pc, 32'h8000_0000);
    chk("rst_addr", o_imem_addr, 32'h8000_0000);

    // zero-wait streaming, one instruction per 3 cycles
    pat = 1'b0; lat = 0; i_ins_ready = 1'b1;
    exp_req.delete(); exp_ins.delete();
    exp_req.push_back(32'h8000_0000); exp_req.push_back(32'h8000_0004);
    exp_req.push_back(32'h8000_0008);
    exp_ins.push_back({32'h8000_0000, 32'h13}); exp_ins.push_back({32'h8000_0004, 32'h13});
    exp_ins.push_back({32'h8000_0008, 32'h13});
    i_rst = 1'b0; mon_en = 1'b1;
    cyc(1);
    chk("first_req_valid", o_imem_req_valid, 1);
    cnt = 0; first = -1; last = -1; spacing_bad = 0;
    for (int c = 1; c <= 8; c++) begin
      cyc(1);
      if (o_ins_valid) begin
        if (first < 0) first = c;
        else if (c - last != 3) spacing_bad++;
        last = c; cnt++;
      end
    end
    chk("stream_count", cnt, 3);
    chk("stream_first", first, 2);
    chk("stream_spacing", spacing_bad, 0);
    drain("stream");

    // decode stall in HOLD
    do_reset();
    pat = 1'b1; i_ins_ready = 1'b0;
    exp_req.push_back(32'h8000_0000); exp_req.push_back(32'h8000_0004);
    exp_ins.push_back({32'h8000_0000, mdata(32'h8000_0000, 1'b1)});
    wait_valid("stall");
    ins0 = o_ins; pc0 = o_pc; rc = req_cnt;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("stall_valid", o_ins_valid, 1);
      chk("stall_ins", o_ins, ins0);
      chk("stall_pc", o_pc, pc0);
      chk("stall_noreq", o_imem_req_valid, 0);
    end
    chk("stall_reqcnt", req_cnt, rc);
    chk("stall_addr_hold", o_imem_addr, 32'h8000_0000);
    i_ins_ready = 1'b1;
    cyc(1);
    chk("stall_addr_next", o_imem_addr, 32'h8000_0004);
    drain("stall");

    // redirect while waiting on a slow response
    do_reset();
    lat = 2; i_ins_ready = 1'b1;
    exp_req.push_back(32'h8000_0000); exp_req.push_back(32'h8000_0100);
    exp_ins.push_back({32'h8000_0100, mdata(32'h8000_0100, 1'b1)});
    cyc(1);
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_0102;
    cyc(1);
    i_redirect_valid = 1'b0;
    chk("wait_redir_addr", o_imem_addr, 32'h8000_0100);
    chk("wait_redir_noreq", o_imem_req_valid, 0);
    chk("wait_redir_noins", o_ins_valid, 0);
    drain("wait_redir");

    // redirect in the same cycle as the HOLD handshake
    do_reset();
    lat = 0; i_ins_ready = 1'b1;
    exp_req.push_back(32'h8000_0000); exp_req.push_back(32'h8000_0200);
    exp_ins.push_back({32'h8000_0000, mdata(32'h8000_0000, 1'b1)});
    exp_ins.push_back({32'h8000_0200, mdata(32'h8000_0200, 1'b1)});
    wait_valid("hold_redir");
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_0200;
    cyc(1);
    i_redirect_valid = 1'b0;
    chk("hold_redir_req", o_imem_req_valid, 1);
    chk("hold_redir_addr", o_imem_addr, 32'h8000_0200);
    drain("hold_redir");

    // access fault: sticky until reset, redirects ignored
    do_reset();
    err_arm = 1'b1;
    exp_req.push_back(32'h8000_0000);
    begin
      int n;
      n = 0;
      while (!o_fetch_err && n < 20) begin cyc(1); n++; end
    end
    chk("err_flag", o_fetch_err, 1);
    chk("err_noins", o_ins_valid, 0);
    rc = req_cnt;
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h8000_0400;
    cyc(1);
    i_redirect_valid = 1'b0;
    cyc(4);
    chk("err_noreq", req_cnt, rc);
    chk("err_req_valid", o_imem_req_valid, 0);
    chk("err_sticky", o_fetch_err, 1);
    chk("err_addr_kept", o_imem_addr, 32'h8000_0000);
    mon_en = 1'b0; i_rst = 1'b1;
    cyc(1);
    chk("err_rst_clear", o_fetch_err, 0);
    chk("err_rst_pc", o_imem_addr, 32'h8000_0000);
    drain("err");

    // redirect in REQ with same-cycle handshake, then pc wrap
    do_reset();
    i_ins_ready = 1'b1;
    exp_req.push_back(32'h8000_0000); exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0000_0000);
    exp_ins.push_back({32'hFFFF_FFFC, mdata(32'hFFFF_FFFC, 1'b1)});
    exp_ins.push_back({32'h0000_0000, mdata(32'h0000_0000, 1'b1)});
    i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    cyc(1);
    i_redirect_valid = 1'b0;
    chk("wrap_kill_noreq", o_imem_req_valid, 0);
    cyc(1);
    chk("wrap_kill_noins", o_ins_valid, 0);
    drain("wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
